// File: rtl/coo_encoder.sv
// COO edge-list writer: scans the adjacency matrix row by row, emits upper-triangle edges.
// Define SELF_LOOP_EN to also emit diagonal (self-loop) entries.
module coo_encoder #(
    parameter int NODES     = 6,
    parameter int MAX_EDGES = 6,
    parameter int NODE_W    = $clog2(NODES + 1),
    parameter int ADDR_W    = $clog2(MAX_EDGES),
    parameter int CNT_W     = $clog2(MAX_EDGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      adj_rd_en,
    output logic [NODE_W-1:0]         adj_rd_addr,
    input  logic [NODES-1:0]          adj_row_in,
    output logic                      coo_wr_en,
    output logic [ADDR_W-1:0]         coo_wr_addr,
    output logic [0:1][NODE_W-1:0]    coo_wr_data,
    output logic [CNT_W-1:0]          edge_count,
    output logic                      overflow,
    output logic                      done_enc
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, SCAN, DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [NODE_W-1:0]        row_q, row_d;
    logic [NODE_W-1:0]        col_q, col_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic [NODES-1:0]         lrow_q, lrow_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [0:1][NODE_W-1:0]   data_q, data_d;
    logic [NODES-1:0]         row_sh;
    logic                     hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            lrow_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            lrow_q  <= lrow_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign row_sh = lrow_q >> col_q;
`ifdef SELF_LOOP_EN
    assign hit = row_sh[0] && (col_q >= row_q);
`else
    assign hit = row_sh[0] && (col_q > row_q);
`endif

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        lrow_d    = lrow_q;
        addr_d    = addr_q;
        data_d    = data_q;
        adj_rd_en = 1'b0;
        coo_wr_en = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                adj_rd_en = 1'b1;
                state_d   = LATCH;
            end
            LATCH: begin
                lrow_d  = adj_row_in;
                col_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (hit) begin
                    if (cnt_q < CNT_W'(MAX_EDGES)) begin
                        coo_wr_en = 1'b1;
                        addr_d    = cnt_q[ADDR_W-1:0];
                        data_d[0] = row_q + NODE_W'(1);
                        data_d[1] = col_q + NODE_W'(1);
                        cnt_d     = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (col_q == NODE_W'(NODES - 1)) begin
                    col_d = '0;
                    if (row_q == NODE_W'(NODES - 1)) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + NODE_W'(1);
                        state_d = FETCH;
                    end
                end else begin
                    col_d = col_q + NODE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // _d equals the live value while writing and the held value otherwise
    assign coo_wr_addr = addr_d;
    assign coo_wr_data = data_d;
    assign adj_rd_addr = row_q;
    assign edge_count  = cnt_q;
    assign overflow    = ovf_q;
    assign done_enc    = (state_q == DONE);

endmodule

// File: tb/tb_coo_encoder.sv
// Directed bench for coo_encoder: adjacency memory model plus captured COO writes.
module tb_coo_encoder;

    localparam int NODES = 6;
    localparam int NW    = 3;
    localparam int AW    = 3;
    localparam int CW    = 3;
    localparam int LAT   = NODES * (NODES + 2) + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  adj_rd_en;
    logic [NW-1:0]         adj_rd_addr;
    logic [NODES-1:0]      adj_row_in = '0;
    logic                  coo_wr_en;
    logic [AW-1:0]         coo_wr_addr;
    logic [0:1][NW-1:0]    coo_wr_data;
    logic [CW-1:0]         edge_count;
    logic                  overflow;
    logic                  done_enc;

    logic [NODES-1:0] adj [0:NODES-1];
    int wa[$];
    int wr[$];
    int wc[$];
    int n_tests = 0;
    int n_fail  = 0;

    coo_encoder dut (
        .clk(clk), .rst(rst), .start(start),
        .adj_rd_en(adj_rd_en), .adj_rd_addr(adj_rd_addr),
        .adj_row_in(adj_row_in),
        .coo_wr_en(coo_wr_en), .coo_wr_addr(coo_wr_addr),
        .coo_wr_data(coo_wr_data), .edge_count(edge_count),
        .overflow(overflow), .done_enc(done_enc)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (adj_rd_en) adj_row_in <= adj[adj_rd_addr];

    always @(negedge clk)
        if (coo_wr_en) begin
            wa.push_back(int'(coo_wr_addr));
            wr.push_back(int'(coo_wr_data[0]));
            wc.push_back(int'(coo_wr_data[1]));
        end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string p);
        check({p, "_done"}, int'(done_enc), 0);
        check({p, "_cnt"}, int'(edge_count), 0);
        check({p, "_ovf"}, int'(overflow), 0);
        check({p, "_wren"}, int'(coo_wr_en), 0);
        check({p, "_rden"}, int'(adj_rd_en), 0);
        check({p, "_raddr"}, int'(adj_rd_addr), 0);
        check({p, "_waddr"}, int'(coo_wr_addr), 0);
        check({p, "_wdata"}, int'(coo_wr_data), 0);
    endtask

    task automatic clear_adj();
        for (int i = 0; i < NODES; i++) adj[i] = '0;
    endtask

    task automatic set_edge(input int a, input int b);
        adj[a][b] = 1'b1;
        adj[b][a] = 1'b1;
    endtask

    // start pulse then wait for done_enc; mid>0 re-pulses start at that cycle
    task automatic run_pass(input string p, input int mid);
        int cyc;
        wa.delete(); wr.delete(); wc.delete();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        check({p, "_done_drop"}, int'(done_enc), 0);
        while (!done_enc && cyc < 200) begin
            if (cyc == mid) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            cyc++;
        end
        check({p, "_latency"}, cyc, LAT);
    endtask

    task automatic chk_writes(input string p, input int n,
                              input int er[6], input int ec[6]);
        check({p, "_nwr"}, wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            check($sformatf("%s_addr%0d", p, i), wa[i], i);
            check($sformatf("%s_row%0d", p, i), wr[i], er[i]);
            check($sformatf("%s_col%0d", p, i), wc[i], ec[i]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r2[6] = '{1, 1, 2, 3, 4, 5};
        int c2[6] = '{2, 6, 3, 4, 5, 6};
        int r3[6] = '{1, 1, 2, 3, 3, 4};
        int c3[6] = '{2, 6, 3, 4, 5, 5};
        int r6[6] = '{1, 4, 0, 0, 0, 0};
        int c6[6] = '{1, 4, 0, 0, 0, 0};

        clear_adj();
        #12 chk_zero("rst");
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk_zero("idle");

        // all-zero matrix
        run_pass("t1", 0);
        check("t1_nwr", wa.size(), 0);
        check("t1_cnt", int'(edge_count), 0);
        check("t1_ovf", int'(overflow), 0);

        // six-edge ring-ish graph fills memory exactly
        set_edge(0, 1); set_edge(1, 2); set_edge(2, 3);
        set_edge(3, 4); set_edge(4, 5); set_edge(0, 5);
        run_pass("t2", 0);
        chk_writes("t2", 6, r2, c2);
        check("t2_cnt", int'(edge_count), 6);
        check("t2_ovf", int'(overflow), 0);
        check("t2_hold_addr", int'(coo_wr_addr), 5);
        check("t2_hold_row", int'(coo_wr_data[0]), 5);
        check("t2_hold_col", int'(coo_wr_data[1]), 6);

        // seventh edge overflows
        set_edge(2, 4);
        run_pass("t3", 0);
        chk_writes("t3", 6, r3, c3);
        check("t3_cnt", int'(edge_count), 6);
        check("t3_ovf", int'(overflow), 1);
        @(posedge clk); #1;
        check("t3_ovf_sticky", int'(overflow), 1);
        check("t3_done_held", int'(done_enc), 1);

        // reset during row-2 scan
        clear_adj();
        set_edge(0, 1); set_edge(1, 2); set_edge(2, 3);
        set_edge(3, 4); set_edge(4, 5); set_edge(0, 5);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 check("t4_pre_cnt", int'(edge_count), 3);
        check("t4_pre_raddr", int'(adj_rd_addr), 2);
        #2 rst = 1'b1;
        #1 chk_zero("t4_rst");
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk_zero("t4_idle");
        run_pass("t4", 0);
        chk_writes("t4", 6, r2, c2);

        // start pulsed in SCAN is ignored; start in DONE restarts
        run_pass("t5a", 12);
        chk_writes("t5a", 6, r2, c2);
        check("t5a_cnt", int'(edge_count), 6);
        run_pass("t5b", 0);
        chk_writes("t5b", 6, r2, c2);
        check("t5b_cnt", int'(edge_count), 6);
        check("t5b_ovf", int'(overflow), 0);

        // diagonal bits only
        clear_adj();
        adj[0][0] = 1'b1;
        adj[3][3] = 1'b1;
        run_pass("t6", 0);
`ifdef SELF_LOOP_EN
        chk_writes("t6", 2, r6, c6);
        check("t6_cnt", int'(edge_count), 2);
`else
        chk_writes("t6", 0, r6, c6);
        check("t6_cnt", int'(edge_count), 0);
`endif
        check("t6_ovf", int'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
